// File: rtl/gate_sequencer.sv
// Sequences stored gate matrices through a shared gate-by-state multiplier,
// writing each product back into the state register until the run completes.
module gate_sequencer #(
    parameter int N        = 3,
    parameter int W        = 8,
    parameter int DEPTH    = 16,
    parameter int MULT_LAT = 1,
    localparam int DIM     = 2 ** N,
    localparam int SW      = 2 * W * DIM,
    localparam int GW      = SW * DIM,
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] num_gates,
    input  logic [SW-1:0] init_state,
    output logic          gate_rd_en,
    output logic [AW-1:0] gate_addr,
    input  logic [GW-1:0] gate_rdata,
    output logic [SW-1:0] mult_state,
    output logic [GW-1:0] mult_gate,
    input  logic [SW-1:0] mult_result,
    input  logic          mult_ovf,
    output logic [SW-1:0] state_out,
    output logic [CW-1:0] gate_idx,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic          ovf_flag
);

    localparam int LW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_MEM,
        EXEC,
        DONE
    } state_e;

    state_e        st;
    logic [GW-1:0] gate_reg;
    logic [CW-1:0] g_total;
    logic [LW-1:0] lat_cnt;
    logic [CW-1:0] idx_nxt;
    logic [CW-1:0] g_req;

    function automatic logic [CW-1:0] clamp_gates(input logic [CW-1:0] n);
        return (n > CW'(DEPTH)) ? CW'(DEPTH) : n;
    endfunction

    assign idx_nxt    = gate_idx + CW'(1);
    assign g_req      = clamp_gates(num_gates);
    assign mult_state = state_out;
    assign mult_gate  = gate_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st         <= IDLE;
            state_out  <= '0;
            gate_reg   <= '0;
            gate_idx   <= '0;
            g_total    <= '0;
            lat_cnt    <= '0;
            ovf_flag   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            gate_rd_en <= 1'b0;
            gate_addr  <= '0;
        end else begin
            done       <= 1'b0;
            aborted    <= 1'b0;
            gate_rd_en <= 1'b0;
            case (st)
                IDLE: begin
                    if (start) begin
                        state_out <= init_state;
                        gate_idx  <= '0;
                        ovf_flag  <= 1'b0;
                        g_total   <= g_req;
                        if (g_req != '0) begin
                            st         <= FETCH;
                            busy       <= 1'b1;
                            gate_rd_en <= 1'b1;
                            gate_addr  <= '0;
                        end else begin
                            st   <= DONE;
                            done <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (abort) begin
                        st      <= IDLE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                    end else begin
                        st <= WAIT_MEM;
                    end
                end
                WAIT_MEM: begin
                    if (abort) begin
                        st      <= IDLE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                    end else begin
                        gate_reg <= gate_rdata;
                        lat_cnt  <= '0;
                        st       <= EXEC;
                    end
                end
                EXEC: begin
                    // Abort outranks the writeback, so a late abort leaves the state untouched.
                    if (abort) begin
                        st      <= IDLE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                    end else if (lat_cnt == LW'(MULT_LAT - 1)) begin
                        state_out <= mult_result;
                        ovf_flag  <= ovf_flag | mult_ovf;
                        gate_idx  <= idx_nxt;
                        if (idx_nxt < g_total) begin
                            st         <= FETCH;
                            gate_rd_en <= 1'b1;
                            gate_addr  <= AW'(idx_nxt);
                        end else begin
                            st   <= DONE;
                            busy <= 1'b0;
                            done <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                DONE: begin
                    st <= IDLE;
                end
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

endmodule
